bus_host_arbiter: RTL and testbench
===================================

// Module: bus_host_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream device port (e.g. u_ram port A) between NrHosts
//  Ibex-protocol hosts (core data port, DMA, debug/trace host). It forwards the winner's request
//  and tracks in-order outstanding transactions. Each response is routed back to the issuing host.
//  Sits between the hosts and bus/ram_2p in the simple system.
// PARAMETERS
//  NrHosts        2   number of requesting hosts (>=2)
//  DataWidth      32  rdata/wdata width
//  AddressWidth   32  address width
//  MaxOutstanding 2   response-tracking FIFO depth (>=1); max accepted-but-unanswered transfers
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  reset, synchronous, active-low
//  host_req_i     in   [NrHosts]          host request
//  host_gnt_o     out  [NrHosts]          host grant (one-hot or zero)
//  host_addr_i    in   [NrHosts][AW]      host address
//  host_we_i      in   [NrHosts]          host write enable
//  host_be_i      in   [NrHosts][DW/8]    host byte enables
//  host_wdata_i   in   [NrHosts][DW]      host write data
//  host_rvalid_o  out  [NrHosts]          response valid (one-hot or zero)
//  host_rdata_o   out  [NrHosts][DW]      response data (all hosts see dev_rdata_i)
//  host_err_o     out  [NrHosts]          response error, qualified by host_rvalid_o
//  dev_req_o      out  1                  downstream request
//  dev_gnt_i      in   1                  downstream grant
//  dev_addr_o/dev_we_o/dev_be_o/dev_wdata_o  out  AW/1/DW/8/DW  winner's request fields
//  dev_rvalid_i   in   1                  downstream response valid (reads and writes)
//  dev_rdata_i    in   DW                 downstream response data
//  dev_err_i      in   1                  downstream response error
// BEHAVIOUR
//  - Request path is combinational; gnt is returned the same cycle as req.
//    dev_req_o = |host_req_i & ~fifo_full_eff.
//  - fifo_full_eff = fifo_full & ~(dev_rvalid_i): a same-cycle pop frees the slot for a push.
//  - Winner: first requesting host at or after rr_ptr, searching upward with wrap (N-1 -> 0).
//    Request fields are muxed from the winner.
//  - Accept = dev_req_o & dev_gnt_i. On accept: host_gnt_o[winner]=1, push winner index,
//    rr_ptr <= (winner+1) mod NrHosts. Without accept rr_ptr holds and all host_gnt_o are 0.
//  - Hosts hold req/fields stable until granted. Arbitration is re-evaluated every cycle, so
//    an ungranted request may lose to a newly raised one. Fairness: no host waits more than
//    NrHosts-1 accepts.
//  - Response path: on dev_rvalid_i, pop head index h; host_rvalid_o[h]=1, host_err_o[h]=dev_err_i.
//    Minimum latency is accept-cycle+1, matching ram_2p. Responses are strictly in order.
//  - dev_rvalid_i with FIFO empty: response dropped, no host_rvalid_o (assertion fires in sim).
//  - FIFO full with no pop: dev_req_o=0, no grants. Full with pop: accept allowed, count unchanged.
//  - Push and pop in the same cycle when empty is illegal (latency>=1). FIFO counter never wraps.
//  - Reset (synchronous, rst_ni=0 at clk edge): rr_ptr=0, FIFO empty, count=0.
//    Registered state clears. Outputs are then 0 unless driven combinationally by inputs.
//    Reset mid-operation discards outstanding entries. Later dev_rvalid_i is dropped per the
//    empty rule.
//  - Combinational outputs when no request: dev_req_o=0, dev_* fields = host 0 fields
//    (don't-care), host_gnt_o=0, host_rvalid_o=0, host_err_o=0.
// STRUCTURE
//  - Package bus_arb_pkg: localparam function host_idx_w(n)=$clog2(n) (min 1), typedef of
//    host index.
//  - Sub-module bus_arb_rsp_fifo: sync FIFO of host indices, depth MaxOutstanding,
//    push/pop/full/empty, same-cycle push+pop when full allowed.
//  - Top holds round-robin pointer, winner search, request mux, response demux.
// TESTING
//  1 host0 req only, dev_gnt_i=1, rvalid next cycle rdata=32'hDEADBEEF
//    -> host_gnt_o=2'b01 same cycle; host_rvalid_o=2'b01 with DEADBEEF.
//  2 both hosts req continuously, gnt always 1, from reset
//    -> grants alternate 01,10,01,10; rr_ptr toggles.
//  3 MaxOutstanding=2, dev_rvalid_i held 0, both req -> two grants, then dev_req_o=0.
//    One rvalid -> third grant issues in that same cycle.
//  4 host1 read (err=1) then host0 write accepted back-to-back
//    -> rvalids route to host1 (err=1) then host0 (err=0), in order.
//  5 rst_ni low for one cycle with 2 entries outstanding, then stray dev_rvalid_i
//    -> no host_rvalid_o, next grant goes to host0.
//  6 dev_gnt_i=0 with host1 requesting for 5 cycles
//    -> host_gnt_o=0, rr_ptr unchanged, dev_addr_o=host1 addr throughout.

Source files
------------

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_arb_pkg                                                      |
// | Brief   : Shared helpers and types for the bus host arbiter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bus_arb_pkg;

    // A single host still needs a one-bit index so that vectors never collapse to zero width.
    function automatic int host_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_DEFAULT_NR_HOSTS = 2;

    typedef logic [host_idx_w(c_DEFAULT_NR_HOSTS)-1:0] host_idx_t;

endpackage
`default_nettype wire

// File: rtl/bus_arb_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_arb_rsp_fifo                                                 |
// | Brief   : Sync FIFO of host indices for outstanding transfers.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_arb_rsp_fifo
    import bus_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == c_DEPTH_CNT);
    assign w_do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign head_o    = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_host_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_host_arbiter                                                 |
// | Brief   : Round-robin arbiter sharing one device port among several hosts. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NR_HOSTS        = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NR_HOSTS-1:0]                      host_req_i,
    output logic [NR_HOSTS-1:0]                      host_gnt_o,
    input  logic [NR_HOSTS-1:0][ADDRESS_WIDTH-1:0]   host_addr_i,
    input  logic [NR_HOSTS-1:0]                      host_we_i,
    input  logic [NR_HOSTS-1:0][DATA_WIDTH/8-1:0]    host_be_i,
    input  logic [NR_HOSTS-1:0][DATA_WIDTH-1:0]      host_wdata_i,
    output logic [NR_HOSTS-1:0]                      host_rvalid_o,
    output logic [NR_HOSTS-1:0][DATA_WIDTH-1:0]      host_rdata_o,
    output logic [NR_HOSTS-1:0]                      host_err_o,
    output logic                                     dev_req_o,
    input  logic                                     dev_gnt_i,
    output logic [ADDRESS_WIDTH-1:0]                 dev_addr_o,
    output logic                                     dev_we_o,
    output logic [DATA_WIDTH/8-1:0]                  dev_be_o,
    output logic [DATA_WIDTH-1:0]                    dev_wdata_o,
    input  logic                                     dev_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    dev_rdata_i,
    input  logic                                     dev_err_i
);

    localparam int c_IDX_W = host_idx_w(NR_HOSTS);
    localparam logic [c_IDX_W-1:0] c_LAST_HOST = c_IDX_W'(NR_HOSTS - 1);

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] w_winner;
    logic [c_IDX_W-1:0] w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_full_eff;
    logic               w_accept;
    logic               w_pop;

    // Searching downward in offset lets the host closest to the pointer be written last and win.
    always_comb begin : p_winner
        int j;
        j        = 0;
        w_winner = '0;
        for (int i = NR_HOSTS - 1; i >= 0; i--) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NR_HOSTS) begin
                j = j - NR_HOSTS;
            end
            if (host_req_i[j]) begin
                w_winner = c_IDX_W'(j);
            end
        end
    end

    assign w_fifo_full_eff = w_fifo_full & ~dev_rvalid_i;
    assign dev_req_o       = (|host_req_i) & ~w_fifo_full_eff;
    assign w_accept        = dev_req_o & dev_gnt_i;
    assign w_pop           = dev_rvalid_i & ~w_fifo_empty;

    assign dev_addr_o  = host_addr_i[w_winner];
    assign dev_we_o    = host_we_i[w_winner];
    assign dev_be_o    = host_be_i[w_winner];
    assign dev_wdata_o = host_wdata_i[w_winner];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_winner == c_LAST_HOST) ? '0 : w_winner + 1'b1;
        end
    end

    always_comb begin
        host_gnt_o = '0;
        if (w_accept) begin
            host_gnt_o[w_winner] = 1'b1;
        end
    end

    bus_arb_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (c_IDX_W)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_accept),
        .push_data_i (w_winner),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    // A response with nothing outstanding is dropped rather than routed to a stale head.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (w_pop) begin
            host_rvalid_o[w_head] = 1'b1;
            host_err_o[w_head]    = dev_err_i;
        end
    end

    generate
        for (genvar g = 0; g < NR_HOSTS; g++) begin : g_rdata
            assign host_rdata_o[g] = dev_rdata_i;
        end
    endgenerate

    always @(posedge clk_i) begin
        assert (!(rst_ni && dev_rvalid_i && w_fifo_empty))
        else $warning("bus_host_arbiter: response with no outstanding transfer dropped");
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_host_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bus_host_arbiter                                              |
// | Brief   : Directed scoreboard bench for the round-robin bus host arbiter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_host_arbiter;
    import bus_arb_pkg::*;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic                       clk_i;
    logic                       rst_ni;
    logic [NH-1:0]              host_req_i;
    logic [NH-1:0]              host_gnt_o;
    logic [NH-1:0][AW-1:0]      host_addr_i;
    logic [NH-1:0]              host_we_i;
    logic [NH-1:0][DW/8-1:0]    host_be_i;
    logic [NH-1:0][DW-1:0]      host_wdata_i;
    logic [NH-1:0]              host_rvalid_o;
    logic [NH-1:0][DW-1:0]      host_rdata_o;
    logic [NH-1:0]              host_err_o;
    logic                       dev_req_o;
    logic                       dev_gnt_i;
    logic [AW-1:0]              dev_addr_o;
    logic                       dev_we_o;
    logic [DW/8-1:0]            dev_be_o;
    logic [DW-1:0]              dev_wdata_o;
    logic                       dev_rvalid_i;
    logic [DW-1:0]              dev_rdata_i;
    logic                       dev_err_i;

    typedef struct {
        host_idx_t   host;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [NH-1:0] mon_oh;
    int n_checks = 0;
    int n_errors = 0;

    bus_host_arbiter #(
        .NR_HOSTS        (NH),
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_addr_o    (dev_addr_o),
        .dev_we_o      (dev_we_o),
        .dev_be_o      (dev_be_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic expect_rsp(input int h, input logic [31:0] d, input logic e);
        exp_t x;
        x.host = host_idx_t'(h);
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic er);
        host_req_i   = req;
        dev_gnt_i    = gnt;
        dev_rvalid_i = rv;
        dev_rdata_i  = rd;
        dev_err_i    = er;
    endtask

    task automatic sample(input string nm, input logic [1:0] gnt_exp, input logic req_exp);
        @(negedge clk_i);
        check({nm, "_gnt"}, 64'(host_gnt_o), 64'(gnt_exp));
        check({nm, "_devreq"}, 64'(dev_req_o), 64'(req_exp));
    endtask

    task automatic do_reset();
        tick();
        rst_ni = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_ni = 1'b1;
    endtask

    // Scoreboard monitor: every presented response must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (host_rvalid_o != '0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rvalid: got rvalid=%b expected none outstanding", host_rvalid_o);
                end else begin
                    mon_e  = sb_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.host] = 1'b1;
                    check("rsp_rvalid", 64'(host_rvalid_o), 64'(mon_oh));
                    check("rsp_rdata", 64'(host_rdata_o[mon_e.host]), 64'(mon_e.data));
                    check("rsp_err", 64'(host_err_o), mon_e.err ? 64'(mon_oh) : 64'(0));
                end
            end else begin
                check("idle_err", 64'(host_err_o), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        host_addr_i  = '0;
        host_addr_i[0] = 32'h0000_1000;
        host_addr_i[1] = 32'h0000_2000;
        host_we_i    = 2'b00;
        host_be_i    = '0;
        host_be_i[0] = 4'hF;
        host_be_i[1] = 4'hF;
        host_wdata_i = '0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_ni = 1'b1;

        // Reset state
        sample("reset", 2'b00, 1'b0);
        check("reset_rvalid", 64'(host_rvalid_o), 64'(0));

        // Test 1: single host read
        tick();
        drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(0, 32'hDEADBEEF, 1'b0);
        sample("t1_req", 2'b01, 1'b1);
        check("t1_addr", 64'(dev_addr_o), 64'(32'h0000_1000));
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        sample("t1_rsp", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // Test 2: continuous contention alternates grants from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            drive(2'b11, 1'b1, (i > 0), 32'hA000_0000 + 32'(i) - 32'd1, 1'b0);
            expect_rsp(i % 2, 32'hA000_0000 + 32'(i), 1'b0);
            sample("t2_alt", (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
        end
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hA000_0003, 1'b0);
        sample("t2_drain", 2'b00, 1'b0);

        // Test 3: outstanding limit, pop frees a slot in the same cycle
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(0, 32'hB000_0001, 1'b0);
        sample("t3_g1", 2'b01, 1'b1);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(1, 32'hB000_0002, 1'b0);
        sample("t3_g2", 2'b10, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
            sample("t3_full", 2'b00, 1'b0);
        end
        tick();
        drive(2'b11, 1'b1, 1'b1, 32'hB000_0001, 1'b0);
        expect_rsp(0, 32'hB000_0003, 1'b0);
        sample("t3_g3", 2'b01, 1'b1);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hB000_0002, 1'b0);
        sample("t3_r2", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hB000_0003, 1'b0);
        sample("t3_r3", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // Test 4: host1 read with error, then host0 write, responses in order
        tick();
        host_we_i = 2'b00;
        drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(1, 32'hC000_0001, 1'b1);
        sample("t4_rd", 2'b10, 1'b1);
        tick();
        host_we_i       = 2'b01;
        host_wdata_i[0] = 32'h5555_AAAA;
        host_be_i[0]    = 4'b0011;
        drive(2'b01, 1'b1, 1'b1, 32'hC000_0001, 1'b1);
        expect_rsp(0, 32'h0, 1'b0);
        sample("t4_wr", 2'b01, 1'b1);
        check("t4_we", 64'(dev_we_o), 64'(1));
        check("t4_wdata", 64'(dev_wdata_o), 64'(32'h5555_AAAA));
        check("t4_be", 64'(dev_be_o), 64'(4'b0011));
        tick();
        host_we_i = 2'b00;
        drive(2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        sample("t4_rsp", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // Test 5: reset discards outstanding entries and the pointer
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        sample("t5_g1", 2'b10, 1'b1);
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        sample("t5_g2", 2'b01, 1'b1);
        tick();
        rst_ni = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        sample("t5_rst", 2'b00, 1'b0);
        tick();
        rst_ni = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        sample("t5_stray", 2'b00, 1'b0);
        check("t5_stray_rvalid", 64'(host_rvalid_o), 64'(0));
        check("t5_stray_err", 64'(host_err_o), 64'(0));
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(0, 32'hD000_0001, 1'b0);
        sample("t5_after", 2'b01, 1'b1);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hD000_0001, 1'b0);
        sample("t5_rsp", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        // Test 6: device stalls, pointer must hold
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
            sample("t6_stall", 2'b00, 1'b1);
            check("t6_addr", 64'(dev_addr_o), 64'(32'h0000_2000));
        end
        tick();
        drive(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_rsp(1, 32'hE000_0001, 1'b0);
        sample("t6_grant", 2'b10, 1'b1);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'hE000_0001, 1'b0);
        sample("t6_rsp", 2'b00, 1'b0);
        tick();
        drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
